// File: rtl/spsram_bist.sv
// March-style self-test initiator for a single-port SRAM: write pattern, read/compare,
// write inverse, read/compare. Reports pass/fail, first failing address/data, and mismatch count.
module spsram_bist #(
  parameter int          BW_DATA = 32,
  parameter int          BW_ADDR = 5,
  parameter int          RD_LAT  = 0,
  parameter logic [31:0] PATTERN = 32'hA5A5_5A5A,
  parameter int          BW_CNT  = 8
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [BW_DATA-1:0] i_mem_data,
  output logic [BW_DATA-1:0] o_mem_data,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic               o_mem_wen,
  output logic               o_mem_cen,
  output logic               o_mem_oen,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [BW_ADDR-1:0] o_fail_addr,
  output logic [BW_DATA-1:0] o_fail_data,
  output logic [BW_CNT-1:0]  o_fail_cnt
);

  localparam int DEPTH = 1 << BW_ADDR;
  // The counter also paces the drain phase, so it needs at least 2 bits for RD_LAT=2.
  localparam int CW    = (BW_ADDR < 2) ? 2 : BW_ADDR;
  localparam int XW    = (BW_ADDR > BW_DATA) ? BW_ADDR : BW_DATA;
  localparam logic [BW_DATA-1:0] PAT    = BW_DATA'(PATTERN);
  localparam logic [CW-1:0]      LAST_A = CW'(DEPTH - 1);
  localparam logic [CW-1:0]      LAST_D = CW'(RD_LAT);

  typedef enum logic [2:0] {IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, DONE} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic               cen_d, wen_d, oen_d, busy_d, done_d, launch_d;
  logic [BW_ADDR-1:0] addr_d;
  logic [BW_DATA-1:0] wdata_d, exp_d;

  logic [RD_LAT:0]              vld_pipe_q;
  logic [RD_LAT:0][BW_DATA-1:0] exp_pipe_q;
  logic [RD_LAT:0][BW_ADDR-1:0] adr_pipe_q;

  logic start_go, miss;

  function automatic logic [BW_DATA-1:0] pat_f(input logic [BW_ADDR-1:0] a, input logic inv);
    logic [XW-1:0] ax;
    ax = XW'(a);
    return (PAT ^ ax[BW_DATA-1:0]) ^ {BW_DATA{inv}};
  endfunction

  assign start_go = ((state_q == IDLE) || (state_q == DONE)) && i_start;
  assign miss     = vld_pipe_q[RD_LAT] && (i_mem_data != exp_pipe_q[RD_LAT]);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = WR0;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == (((state_q == DRN0) || (state_q == DRN1)) ? LAST_D : LAST_A)) begin
          state_d = state_e'(state_q + 3'd1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Bus values are derived from the next state so the registered outputs line up with it.
  always_comb begin
    cen_d    = 1'b0;
    wen_d    = 1'b0;
    oen_d    = 1'b0;
    launch_d = 1'b0;
    addr_d   = '0;
    wdata_d  = o_mem_data;
    exp_d    = pat_f(cnt_d[BW_ADDR-1:0], state_d == RD1);
    busy_d   = (state_d != IDLE) && (state_d != DONE);
    done_d   = (state_d == DONE);
    case (state_d)
      WR0, WR1: begin
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        addr_d  = cnt_d[BW_ADDR-1:0];
        wdata_d = pat_f(cnt_d[BW_ADDR-1:0], state_d == WR1);
      end
      RD0, RD1: begin
        cen_d    = 1'b1;
        oen_d    = 1'b1;
        launch_d = 1'b1;
        addr_d   = cnt_d[BW_ADDR-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mem_cen  <= 1'b0;
      o_mem_wen  <= 1'b0;
      o_mem_oen  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_mem_cen  <= cen_d;
      o_mem_wen  <= wen_d;
      o_mem_oen  <= oen_d;
      o_mem_addr <= addr_d;
      o_mem_data <= wdata_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_pipe_q <= '0;
      exp_pipe_q <= '0;
      adr_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= launch_d;
      exp_pipe_q[0] <= exp_d;
      adr_pipe_q[0] <= addr_d;
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        exp_pipe_q[i] <= exp_pipe_q[i-1];
        adr_pipe_q[i] <= adr_pipe_q[i-1];
      end
    end
  end

  // Drain guarantees no compare lands on the start or done edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_pass      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_fail_cnt  <= '0;
    end else if (start_go) begin
      o_pass      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
      o_fail_cnt  <= '0;
    end else begin
      if (miss) begin
        if (o_fail_cnt != '1) o_fail_cnt <= o_fail_cnt + BW_CNT'(1);
        if (o_fail_cnt == '0) begin
          o_fail_addr <= adr_pipe_q[RD_LAT];
          o_fail_data <= i_mem_data;
        end
      end
      if ((state_q == DRN1) && (state_d == DONE)) o_pass <= (o_fail_cnt == '0);
    end
  end

endmodule

// File: tb/tb_spsram_bist.sv
// Bench for spsram_bist: async-read (RD_LAT=0) and registered-read (RD_LAT=1, BW_CNT=4) instances
// with behavioural SRAM models, cycle-exact bus checks and a result scoreboard.
module tb_spsram_bist;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start [2];
  logic        cen [2], wen [2], oen [2], busy [2], done [2], pass [2];
  logic [31:0] wdata [2], rdata [2], fdata [2];
  logic [4:0]  addr [2], faddr [2];
  logic [7:0]  fcnt0;
  logic [3:0]  fcnt1;

  logic [31:0] mem [2][D];
  int          fmode [2];
  logic [31:0] rq;
  logic [4:0]  ra;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {int t_done; bit pass; int cnt; int faddr; logic [31:0] fdata;} exp_t;
  exp_t sb[$];

  spsram_bist u_dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start[0]), .i_mem_data(rdata[0]),
    .o_mem_data(wdata[0]), .o_mem_addr(addr[0]), .o_mem_wen(wen[0]), .o_mem_cen(cen[0]),
    .o_mem_oen(oen[0]), .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]),
    .o_fail_addr(faddr[0]), .o_fail_data(fdata[0]), .o_fail_cnt(fcnt0)
  );

  spsram_bist #(.RD_LAT(1), .BW_CNT(4)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start[1]), .i_mem_data(rdata[1]),
    .o_mem_data(wdata[1]), .o_mem_addr(addr[1]), .o_mem_wen(wen[1]), .o_mem_cen(cen[1]),
    .o_mem_oen(oen[1]), .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]),
    .o_fail_addr(faddr[1]), .o_fail_data(fdata[1]), .o_fail_cnt(fcnt1)
  );

  function automatic logic [31:0] corrupt(input int m, input logic [4:0] a, input logic [31:0] d);
    case (m)
      1: return (a == 5'd7) ? (d ^ 32'd1) : d;
      2: return 32'd0;
      default: return d;
    endcase
  endfunction

  // SRAM models: instance 0 async read, instance 1 registered read.
  always @(posedge clk) begin
    if (cen[0] && wen[0]) mem[0][addr[0]] <= wdata[0];
    if (cen[1] && wen[1]) mem[1][addr[1]] <= wdata[1];
    if (cen[1] && !wen[1]) begin
      rq <= mem[1][addr[1]];
      ra <= addr[1];
    end
  end
  always_comb rdata[0] = corrupt(fmode[0], addr[0], mem[0][addr[0]]);
  always_comb rdata[1] = corrupt(fmode[1], ra, rq);

  function automatic logic [31:0] d0(input int a);
    return 32'hA5A5_5A5A ^ 32'(a);
  endfunction

  function automatic int get_cnt(input int g);
    return (g != 0) ? int'(fcnt1) : int'(fcnt0);
  endfunction

  function automatic logic [87:0] all_outs(input int g);
    return {cen[g], wen[g], oen[g], busy[g], done[g], pass[g], addr[g], wdata[g],
            faddr[g], fdata[g], (g != 0) ? {4'b0, fcnt1} : fcnt0};
  endfunction

  // Expected {cen,wen,oen,addr} at edge k+t, write data, and whether it is a write.
  function automatic void exp_bus(input int t, input int rl, output logic [7:0] b,
                                  output logic [31:0] d, output bit wr);
    int w1;
    w1 = 2*D + rl + 1;
    b = '0; d = '0; wr = 1'b0;
    if (t < D) begin
      b = {3'b110, 5'(t)}; d = d0(t); wr = 1'b1;
    end else if (t < 2*D) begin
      b = {3'b101, 5'(t-D)};
    end else if (t >= w1 && t < w1 + D) begin
      b = {3'b110, 5'(t-w1)}; d = ~d0(t-w1); wr = 1'b1;
    end else if (t >= w1 + D && t < w1 + 2*D) begin
      b = {3'b101, 5'(t-w1-D)};
    end
  endfunction

  task automatic run_test(input string name, input int g, input int fm, input bit ep,
                          input int ec, input int efa, input logic [31:0] efd, input int mid_t);
    int T;
    bit got;
    logic [7:0] eb, ab;
    logic [31:0] ed;
    bit wr;
    exp_t e;
    T = 4*D + 2*g + 2;
    got = 1'b0;
    fmode[g] = fm;
    sb.push_back('{T, ep, ec, efa, efd});
    @(negedge clk) start[g] = 1'b1;
    for (int t = 0; t <= T + 10 && !got; t++) begin
      @(posedge clk); #1;
      start[g] = ((t + 1) == mid_t);
      if (t == 0) begin
        n_chk++;
        if ({done[g], pass[g], faddr[g], fdata[g]} !== '0 || get_cnt(g) != 0 || busy[g] !== 1'b1) begin
          n_fail++;
          $display("FAIL %s start_clear: done=%b pass=%b faddr=%0d fdata=%h cnt=%0d busy=%b, want all 0 and busy=1",
                   name, done[g], pass[g], faddr[g], fdata[g], get_cnt(g), busy[g]);
        end
      end
      exp_bus(t, g, eb, ed, wr);
      ab = {cen[g], wen[g], oen[g], addr[g]};
      n_chk++;
      if (ab !== eb) begin
        n_fail++;
        $display("FAIL %s bus t=%0d: got cen/wen/oen/addr=%b, want %b", name, t, ab, eb);
      end
      if (wr) begin
        n_chk++;
        if (wdata[g] !== ed) begin
          n_fail++;
          $display("FAIL %s wdata t=%0d: got %h, want %h", name, t, wdata[g], ed);
        end
      end
      if (t < T) begin
        n_chk++;
        if (busy[g] !== 1'b1 || done[g] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy t=%0d: got busy=%b done=%b, want 1/0", name, t, busy[g], done[g]);
        end
      end
      if (done[g] === 1'b1) begin
        got = 1'b1;
        e = sb.pop_front();
        n_chk++;
        if (t != e.t_done || busy[g] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done_edge: got k+%0d busy=%b, want k+%0d busy=0", name, t, busy[g], e.t_done);
        end
        n_chk++;
        if (pass[g] !== e.pass || get_cnt(g) != e.cnt) begin
          n_fail++;
          $display("FAIL %s result: got pass=%b cnt=%0d, want pass=%b cnt=%0d",
                   name, pass[g], get_cnt(g), e.pass, e.cnt);
        end
        n_chk++;
        if (int'(faddr[g]) != e.faddr || fdata[g] !== e.fdata) begin
          n_fail++;
          $display("FAIL %s fail_info: got addr=%0d data=%h, want addr=%0d data=%h",
                   name, faddr[g], fdata[g], e.faddr, e.fdata);
        end
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: o_done not seen by k+%0d, want k+%0d", name, T + 10, T);
      void'(sb.pop_front());
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (done[g] !== 1'b1 || pass[g] !== ep || cen[g] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_hold: got done=%b pass=%b cen=%b, want 1/%b/0", name, done[g], pass[g], cen[g], ep);
    end
  endtask

  task automatic test_reset;
    #1;
    for (int g = 0; g < 2; g++) begin
      n_chk++;
      if (all_outs(g) !== '0) begin
        n_fail++;
        $display("FAIL reset_outs dut%0d: got %h, want 0", g, all_outs(g));
      end
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_pass_async;
    run_test("async_pass", 0, 0, 1'b1, 0, 0, 32'h0, -1);
    n_chk++;
    if (mem[0][5] !== 32'h5A5A_A5A0) begin
      n_fail++;
      $display("FAIL mem_addr5: got %h, want 5a5aa5a0", mem[0][5]);
    end
  endtask

  task automatic test_bit_flip;
    run_test("bit_flip", 0, 1, 1'b0, 2, 7, 32'hA5A5_5A5C, -1);
  endtask

  task automatic test_restart_from_done;
    run_test("restart", 0, 0, 1'b1, 0, 0, 32'h0, -1);
  endtask

  task automatic test_rdlat1;
    run_test("rdlat1", 1, 0, 1'b1, 0, 0, 32'h0, -1);
  endtask

  task automatic test_saturate;
    run_test("saturate", 1, 2, 1'b0, 15, 0, 32'h0, -1);
    run_test("sat_recover", 1, 0, 1'b1, 0, 0, 32'h0, -1);
  endtask

  task automatic test_start_while_busy;
    run_test("busy_start", 0, 0, 1'b1, 0, 0, 32'h0, 40);
  endtask

  task automatic test_reset_abort;
    fmode[0] = 0;
    @(negedge clk) start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (2*D + 1 + 5) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      n_chk++;
      if (all_outs(g) !== '0) begin
        n_fail++;
        $display("FAIL abort_async dut%0d: got %h, want 0", g, all_outs(g));
      end
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({cen[0], wen[0], oen[0], busy[0], done[0]} !== 5'b0) begin
        n_fail++;
        $display("FAIL abort_idle cyc%0d: got cen/wen/oen/busy/done=%b, want 00000",
                 i, {cen[0], wen[0], oen[0], busy[0], done[0]});
      end
    end
    run_test("after_abort", 0, 0, 1'b1, 0, 0, 32'h0, -1);
  endtask

  initial begin
    start[0] = 1'b0; start[1] = 1'b0;
    fmode[0] = 0; fmode[1] = 0;
    test_reset;
    test_pass_async;
    test_bit_flip;
    test_restart_from_done;
    test_rdlat1;
    test_saturate;
    test_start_while_busy;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
